// File: rtl/match_pkg.sv
// Shared widths, trailer field positions and the FIFO entry layout for the match stream packer.
package match_pkg;

    localparam int MATCH_W = 64;
    localparam int ENTRY_W = MATCH_W + 1;

    localparam int TRL_TAG_HI   = 63;
    localparam int TRL_SEQ_LSB  = 32;
    localparam int TRL_CNT_LSB  = 16;
    localparam int TRL_DROP_LSB = 0;

    localparam logic [15:0] TRL_MARKER_DEFAULT = 16'hF00D;

    typedef struct packed {
        logic               is_trailer;
        logic [MATCH_W-1:0] data;
    } entry_t;

    function automatic logic [MATCH_W-1:0] make_trailer(
        input logic [15:0] marker,
        input logic [15:0] seq,
        input logic [15:0] cnt,
        input logic [15:0] drop
    );
        logic [MATCH_W-1:0] t;
        t = '0;
        t[TRL_TAG_HI -: 16]   = marker;
        t[TRL_SEQ_LSB +: 16]  = seq;
        t[TRL_CNT_LSB +: 16]  = cnt;
        t[TRL_DROP_LSB +: 16] = drop;
        return t;
    endfunction

endpackage

// File: rtl/match_stream_packer_if.sv
// Upstream match stream (no backpressure) plus the downstream valid/ready stream.
interface match_stream_packer_if;
    import match_pkg::*;

    logic               in_valid;
    logic [MATCH_W-1:0] in_data;
    logic               in_last;
    logic               m_valid;
    logic [MATCH_W-1:0] m_data;
    logic               m_last;
    logic               m_ready;

    modport slave (
        input  in_valid, in_data, in_last, m_ready,
        output m_valid, m_data, m_last
    );

    modport master (
        output in_valid, in_data, in_last, m_ready,
        input  m_valid, m_data, m_last
    );

endinterface

// File: rtl/match_sync_fifo.sv
// Single-clock FIFO with occupancy output and a registered read port.
module match_sync_fifo #(
    parameter int WIDTH = 65,
    parameter int AW    = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_wr_en,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_rd_en,
    output logic [WIDTH-1:0] o_rd_data,
    output logic [AW:0]      o_level
);

    localparam int          DEPTH = 2 ** AW;
    localparam logic [AW:0] FULL  = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_level;
    logic [WIDTH-1:0] r_rd_data;
    logic             w_wr;
    logic             w_rd;

    assign w_wr      = i_wr_en && (r_level != FULL);
    assign w_rd      = i_rd_en && (r_level != '0);
    assign o_level   = r_level;
    assign o_rd_data = r_rd_data;

    // Storage is left unreset so it can map onto block RAM.
    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wptr] <= i_wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_level   <= '0;
            r_rd_data <= '0;
        end else begin
            if (w_wr) r_wptr <= r_wptr + 1'b1;
            if (w_rd) begin
                r_rptr    <= r_rptr + 1'b1;
                r_rd_data <= r_mem[r_rptr];
            end
            r_level <= r_level + {{AW{1'b0}}, w_wr} - {{AW{1'b0}}, w_rd};
        end
    end

endmodule

// File: rtl/match_stream_packer.sv
// Buffers the match stream, appends one trailer per frame and re-emits it as valid/ready.
module match_stream_packer
    import match_pkg::*;
#(
    parameter int          FIFO_AW    = 9,
    parameter logic [15:0] TRL_MARKER = TRL_MARKER_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    match_stream_packer_if.slave  io_bus,
    output logic [FIFO_AW:0]      o_fifo_level,
    output logic                  o_ovf_sticky,
    output logic                  o_lost_sticky
);

    localparam logic [FIFO_AW:0] FULL_LEVEL = (FIFO_AW + 1)'(2 ** FIFO_AW);
    localparam logic [FIFO_AW:0] DATA_LIMIT = (FIFO_AW + 1)'(2 ** FIFO_AW - 1);

    logic [15:0]        r_seq;
    logic [15:0]        r_cnt;
    logic [15:0]        r_drop;
    logic               r_trl_pend;
    logic               r_trl_wait;
    logic [MATCH_W-1:0] r_trl_data;
    logic               r_skid_vld;
    logic [MATCH_W-1:0] r_skid_data;
    logic               r_rdv;
    logic               r_m_valid;
    logic [MATCH_W-1:0] r_m_data;
    logic               r_m_last;
    logic               r_ovf;
    logic               r_lost;

    logic [FIFO_AW:0]   w_level;
    logic               w_data_ok;
    logic               w_trl_ok;
    logic               w_trl_first;
    logic               w_sel_trl;
    logic               w_sel_skid;
    logic               w_sel_live;
    logic               w_to_skid;
    logic               w_in_store;
    logic               w_in_drop;
    logic               w_eof;
    logic               w_skid_vld_nxt;
    logic [15:0]        w_cnt_now;
    logic [15:0]        w_drop_now;
    logic [MATCH_W-1:0] w_trl_new;
    logic               w_wr_en;
    entry_t             w_wr_data;
    entry_t             w_rd_data;
    logic               w_out_adv;
    logic               w_rd_adv;
    logic               w_rd_en;

    assign w_data_ok = w_level < DATA_LIMIT;
    assign w_trl_ok  = w_level < FULL_LEVEL;

    // A trailer queued while its own frame's word sits in the skid must let that word go first.
    assign w_trl_first = r_trl_pend && !(r_skid_vld && r_trl_wait);
    assign w_sel_trl   = w_trl_first && w_trl_ok;
    assign w_sel_skid  = !w_trl_first && r_skid_vld && w_data_ok;
    assign w_sel_live  = !r_trl_pend && !r_skid_vld && io_bus.in_valid && w_data_ok;
    assign w_to_skid   = io_bus.in_valid && !w_sel_live && (w_sel_trl || w_sel_skid)
                         && (!r_skid_vld || w_sel_skid);

    assign w_in_store     = w_sel_live || w_to_skid;
    assign w_in_drop      = io_bus.in_valid && !w_in_store;
    assign w_eof          = io_bus.in_valid && io_bus.in_last;
    assign w_skid_vld_nxt = w_to_skid || (r_skid_vld && !w_sel_skid);
    assign w_cnt_now      = r_cnt + {15'd0, w_in_store};
    assign w_drop_now     = (w_in_drop && (r_drop != 16'hFFFF)) ? r_drop + 16'd1 : r_drop;
    assign w_trl_new      = make_trailer(TRL_MARKER, r_seq, w_cnt_now, w_drop_now);
    assign w_wr_en        = w_sel_trl || w_sel_skid || w_sel_live;

    always_comb begin
        w_wr_data.is_trailer = 1'b0;
        w_wr_data.data       = io_bus.in_data;
        if (w_sel_trl) begin
            w_wr_data.is_trailer = 1'b1;
            w_wr_data.data       = r_trl_data;
        end else if (w_sel_skid) begin
            w_wr_data.data = r_skid_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seq       <= '0;
            r_cnt       <= '0;
            r_drop      <= '0;
            r_trl_pend  <= 1'b0;
            r_trl_wait  <= 1'b0;
            r_trl_data  <= '0;
            r_skid_vld  <= 1'b0;
            r_skid_data <= '0;
            r_ovf       <= 1'b0;
            r_lost      <= 1'b0;
        end else begin
            r_skid_vld <= w_skid_vld_nxt;
            if (w_to_skid) r_skid_data <= io_bus.in_data;
            if (w_in_drop) r_ovf <= 1'b1;
            if (w_eof) begin
                r_trl_data <= w_trl_new;
                r_trl_pend <= 1'b1;
                r_trl_wait <= w_skid_vld_nxt;
                r_seq      <= r_seq + 16'd1;
                r_cnt      <= '0;
                r_drop     <= '0;
                if (r_trl_pend && !w_sel_trl) r_lost <= 1'b1;
            end else begin
                r_cnt  <= w_cnt_now;
                r_drop <= w_drop_now;
                if (w_sel_trl) r_trl_pend <= 1'b0;
                if (w_sel_skid) r_trl_wait <= 1'b0;
            end
        end
    end

    match_sync_fifo #(
        .WIDTH (ENTRY_W),
        .AW    (FIFO_AW)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_wr_en   (w_wr_en),
        .i_wr_data (w_wr_data),
        .i_rd_en   (w_rd_en),
        .o_rd_data (w_rd_data),
        .o_level   (w_level)
    );

    // Two-stage read: FIFO read register, then the held output register.
    assign w_out_adv = !r_m_valid || io_bus.m_ready;
    assign w_rd_adv  = !r_rdv || w_out_adv;
    assign w_rd_en   = w_rd_adv && (w_level != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdv     <= 1'b0;
            r_m_valid <= 1'b0;
            r_m_data  <= '0;
            r_m_last  <= 1'b0;
        end else begin
            if (w_rd_adv) r_rdv <= w_rd_en;
            if (w_out_adv) begin
                r_m_valid <= r_rdv;
                if (r_rdv) begin
                    r_m_data <= w_rd_data.data;
                    r_m_last <= w_rd_data.is_trailer;
                end
            end
        end
    end

    assign io_bus.m_valid = r_m_valid;
    assign io_bus.m_data  = r_m_data;
    assign io_bus.m_last  = r_m_last;
    assign o_fifo_level   = w_level;
    assign o_ovf_sticky   = r_ovf;
    assign o_lost_sticky  = r_lost;

endmodule

// File: tb/tb_match_stream_packer.sv
// Scoreboard bench for match_stream_packer with an 8-entry FIFO and directed frames.
module tb_match_stream_packer;
    import match_pkg::*;

    localparam int AW = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [AW:0] fifoLevel;
    logic        ovfSticky;
    logic        lostSticky;

    logic [64:0] sb [$];
    int          checks = 0;
    int          passes = 0;
    logic        holdPending = 1'b0;
    logic [64:0] heldWord = '0;

    match_stream_packer_if bus ();

    match_stream_packer #(
        .FIFO_AW    (AW),
        .TRL_MARKER (16'hF00D)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .io_bus        (bus),
        .o_fifo_level  (fifoLevel),
        .o_ovf_sticky  (ovfSticky),
        .o_lost_sticky (lostSticky)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [64:0] act, input logic [64:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic applyStimulus(input logic [63:0] data, input logic last, input logic stored);
        bus.in_valid = 1'b1;
        bus.in_data  = data;
        bus.in_last  = last;
        if (stored) sb.push_back({1'b0, data});
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic expectTrailer(input logic [15:0] seq, input logic [15:0] cnt, input logic [15:0] drop);
        sb.push_back({1'b1, 16'hF00D, seq, cnt, drop});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic waitDrain(input string name, input logic toggle);
        for (int i = 0; i < 200; i++) begin
            if (sb.size() == 0 && !bus.m_valid) break;
            if (toggle) bus.m_ready = ~bus.m_ready;
            @(posedge clk);
            #1;
        end
        bus.m_ready = 1'b1;
        checkOutput({name, "_queueEmpty"}, 65'(sb.size()), 65'd0);
        checkOutput({name, "_validLow"}, 65'(bus.m_valid), 65'd0);
    endtask

    // Monitor: hold stability while stalled, and scoreboard pop on each accepted word.
    always @(negedge clk) begin
        if (!rst_n) begin
            holdPending = 1'b0;
        end else begin
            if (holdPending) begin
                checkOutput("holdValid", 65'(bus.m_valid), 65'd1);
                checkOutput("holdWord", {bus.m_last, bus.m_data}, heldWord);
            end
            if (bus.m_valid && bus.m_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    $display("[TB] FAIL unexpectedWord: got %h, expected no word", {bus.m_last, bus.m_data});
                end else begin
                    checkOutput("outWord", {bus.m_last, bus.m_data}, sb.pop_front());
                end
            end
            holdPending = bus.m_valid && !bus.m_ready;
            heldWord    = {bus.m_last, bus.m_data};
        end
    end

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.in_last  = 1'b0;
        bus.m_ready  = 1'b1;

        #12;
        checkOutput("rstValid", 65'(bus.m_valid), 65'd0);
        checkOutput("rstWord", {bus.m_last, bus.m_data}, 65'd0);
        checkOutput("rstLevel", 65'(fifoLevel), 65'd0);
        checkOutput("rstFlags", 65'({ovfSticky, lostSticky}), 65'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single frame A,B,C
        applyStimulus(64'hAAAA_0000_0000_000A, 1'b0, 1'b1);
        applyStimulus(64'hBBBB_0000_0000_000B, 1'b0, 1'b1);
        applyStimulus(64'hCCCC_0000_0000_000C, 1'b1, 1'b1);
        expectTrailer(16'd0, 16'd3, 16'd0);
        waitDrain("single", 1'b0);

        // Back-to-back: trailer slot pushes D into the skid; D is itself a 1-word frame
        applyStimulus(64'h0000_0000_0000_00E0, 1'b0, 1'b1);
        applyStimulus(64'h0000_0000_0000_00E1, 1'b1, 1'b1);
        expectTrailer(16'd1, 16'd2, 16'd0);
        applyStimulus(64'hDDDD_0000_0000_000D, 1'b1, 1'b1);
        expectTrailer(16'd2, 16'd1, 16'd0);
        waitDrain("backToBack", 1'b0);
        checkOutput("b2bNoOvf", 65'(ovfSticky), 65'd0);

        // Backpressure: m_ready toggles every cycle
        for (int i = 0; i < 5; i++) begin
            bus.m_ready = ~bus.m_ready;
            applyStimulus(64'h5555_0000_0000_0000 + 64'(i), (i == 4), 1'b1);
        end
        expectTrailer(16'd3, 16'd5, 16'd0);
        waitDrain("backpressure", 1'b1);

        // Overflow: fill the output pipeline with a 1-word frame, then 10 words into 8 slots
        bus.m_ready = 1'b0;
        applyStimulus(64'h7777_0000_0000_0077, 1'b1, 1'b1);
        expectTrailer(16'd4, 16'd1, 16'd0);
        idle(5);
        checkOutput("ovfPipeFull", 65'(fifoLevel), 65'd0);
        for (int i = 0; i < 10; i++)
            applyStimulus(64'h9999_0000_0000_0000 + 64'(i), (i == 9), (i < 7));
        expectTrailer(16'd5, 16'd7, 16'd3);
        idle(3);
        checkOutput("ovfLevel", 65'(fifoLevel), 65'd8);
        checkOutput("ovfSticky", 65'(ovfSticky), 65'd1);
        checkOutput("ovfNoLoss", 65'(lostSticky), 65'd0);

        // Trailer loss: FIFO full, two lasts; only seq 7 survives
        applyStimulus(64'h1111_0000_0000_0006, 1'b1, 1'b0);
        applyStimulus(64'h1111_0000_0000_0007, 1'b1, 1'b0);
        expectTrailer(16'd7, 16'd0, 16'd1);
        idle(2);
        checkOutput("lostSticky", 65'(lostSticky), 65'd1);
        checkOutput("lostLevel", 65'(fifoLevel), 65'd8);
        bus.m_ready = 1'b1;
        waitDrain("overflowLoss", 1'b0);

        // Reset mid-frame with words queued
        bus.m_ready = 1'b0;
        applyStimulus(64'h2222_0000_0000_0001, 1'b0, 1'b0);
        applyStimulus(64'h2222_0000_0000_0002, 1'b0, 1'b0);
        applyStimulus(64'h2222_0000_0000_0003, 1'b0, 1'b0);
        idle(4);
        #3;
        rst_n = 1'b0;
        sb.delete();
        #1;
        checkOutput("midRstValid", 65'(bus.m_valid), 65'd0);
        checkOutput("midRstLevel", 65'(fifoLevel), 65'd0);
        checkOutput("midRstFlags", 65'({ovfSticky, lostSticky}), 65'd0);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        bus.m_ready = 1'b1;
        applyStimulus(64'h3333_0000_0000_0033, 1'b1, 1'b1);
        expectTrailer(16'd0, 16'd1, 16'd0);
        waitDrain("afterReset", 1'b0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/match_stream_packer.md
Name: match_stream_packer

Overview:
- Sits directly downstream of the feature-processing top. It consumes the match-result stream (valid/64-bit data/last), which has no backpressure.
- Buffers the stream in a FIFO and re-emits it as a valid/ready stream to the DMA/host link.
- Appends one trailer word per frame carrying the frame sequence number, the stored-match count and the dropped-match count.
- Drops words under overflow rather than stalling upstream. Drops are counted and reported.

Parameters:
- FIFO_AW, 9, FIFO address width. Depth = 2**FIFO_AW entries; minimum 3.
- TRL_MARKER, 16'hF00D, tag placed in trailer bits [63:48].

Ports:
- clk  in  1  single clock for the whole block.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- in_valid  in  1  match word present; no ready, so the word must be taken or dropped this cycle.
- in_data  in  64  match word.
- in_last  in  1  final match word of the frame; qualified by in_valid.
- m_valid  out  1  output word valid.
- m_data  out  64  output word.
- m_last  out  1  high only on trailer words.
- m_ready  in  1  downstream accept.
- fifo_level  out  FIFO_AW+1  current FIFO occupancy.
- ovf_sticky  out  1  set when any word is dropped; cleared only by reset.
- lost_sticky  out  1  set when a pending trailer is overwritten; cleared only by reset.

Behaviour:
- Reset (rst=0, asynchronous): m_valid=0, m_data=0, m_last=0, fifo_level=0, both sticky flags 0, frame_seq=0, per-frame counters 0, skid empty, no pending trailer.
- FIFO entry format: 65 bits, {is_trailer, data}.
- Write path, one FIFO write per cycle. Priority order:
  1. Pending trailer register.
  2. Skid register.
  3. Live input.
- Admission limits:
  - Data words are written only when level < DEPTH-1.
  - Trailers may also use the last slot (level < DEPTH).
  - A data word arriving at a full limit is dropped: frame drop count +1 (saturating at 16'hFFFF), ovf_sticky=1.
- Skid register (1 deep):
  - If live in_valid coincides with a higher-priority write, the word goes to the skid.
  - If the skid is occupied and not written this cycle, the new word is dropped and counted.
  - The skid empties on any cycle it wins the write slot.
- End of frame: on in_valid&&in_last, whether the word is stored or dropped:
  - Load the pending trailer register with {TRL_MARKER, frame_seq[15:0], stored_cnt[15:0], drop_cnt[15:0]}. Both counts include this word.
  - Then frame_seq+1 (wraps at 16 bits) and both per-frame counters clear.
  - The trailer is written in the next cycle with free space, ahead of any later frame data, so ordering is preserved.
- Simultaneous event: if a new last arrives while a trailer is still pending (FIFO full), the new trailer overwrites the pending one and lost_sticky=1. The consumer sees the gap in frame_seq.
- Read path:
  - Registered output stage popping the FIFO when !m_valid || m_ready.
  - m_last = is_trailer.
  - m_data, m_last and m_valid are held stable while m_valid && !m_ready.
- Latency: with an empty FIFO and m_ready=1, a word sampled at edge k is presented on m_data after edge k+2.
- Throughput: 1 word/cycle in steady state. The trailer costs one write slot, absorbed by the skid, which drains on the next idle input cycle.
- fifo_level counts FIFO entries only; the skid and the output register are excluded.
- Reset mid-frame: all content is discarded, and the output restarts cleanly at frame_seq=0.

Decomposition:
- Shared package (match_pkg):
  - MATCH_W=64.
  - Trailer field localparams: TRL_TAG_HI=63, TRL_SEQ_LSB=32, TRL_CNT_LSB=16, TRL_DROP_LSB=0.
  - Entry width 65.
  - Default TRL_MARKER.
- One sub-module: match_sync_fifo.
  - Width/depth-parameterised, single clock, async active-low reset.
  - Provides level output and registered read.
- Packer logic, skid register and trailer logic live in the top.

Test Plan:
- Single frame: 3 words A,B,C with last on C, m_ready=1 -> output A,B,C (m_last=0), then 64'hF00D_0000_0003_0000 with m_last=1.
- Back-to-back frames: 2-word frame ending in last, next frame word D on the following cycle -> output order w0, w1, trailer seq 0 cnt 2, D. No drop; ovf_sticky=0.
- Overflow: FIFO_AW=3, m_ready=0, 10 words with last on the 10th -> 7 words stored, 3 dropped. Trailer 64'hF00D_0000_0007_0003 occupies slot 8; fifo_level=8; ovf_sticky=1.
- Backpressure hold: toggle m_ready every cycle during a 5-word frame -> m_data/m_last unchanged while m_valid&&!m_ready. All 5 words plus the trailer delivered exactly once.
- Trailer loss: m_ready=0, FIFO full, two lasts arrive -> only the second trailer (seq 1) is output; lost_sticky=1.
- Reset: assert rst mid-frame with data queued -> m_valid=0 and fifo_level=0 immediately. The next frame's trailer carries seq 0.
